// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES byte-to-block assembler.
//   aes_block_t      : one 128-bit AES state block
//   AES_BLOCK_BYTES  : bytes per block
//   AES_BYTE_CNT_W   : width of the in-block byte counter
//   wr_state_t       : write-side FSM states (IDLE = counter 0, FILLING = partial block)
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BYTE_CNT_W  = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic {
        WR_IDLE    = 1'b0,
        WR_FILLING = 1'b1
    } wr_state_t;

endpackage

// File: rtl/aes_block_slot_buf.sv
// ---------------------------------------------------------------------------
// aes_block_slot_buf
// DEPTH-entry ping-pong store of 128-bit blocks with per-slot full flags,
// write/read pointers and a complete-block level count.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset (control state only)
//   i_ce           : clock enable, gates the pop
//   i_wr_en        : write i_wr_byte into byte lane i_wr_idx of the write slot
//   i_wr_idx       : byte lane 0..15 (lane 0 = bits [7:0])
//   i_wr_byte      : byte to store
//   i_wr_commit    : mark the write slot full and advance the write pointer
//   i_rd_ready     : consumer takes the block at the read slot
//   o_wr_full      : write slot is occupied by a complete block
//   o_rd_block     : block at the read slot (zero while the slot is empty)
//   o_rd_valid     : read slot holds a complete block
//   o_level        : number of complete blocks held
// ---------------------------------------------------------------------------
module aes_block_slot_buf
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ce,
    input  logic                      i_wr_en,
    input  logic [AES_BYTE_CNT_W-1:0] i_wr_idx,
    input  logic [7:0]                i_wr_byte,
    input  logic                      i_wr_commit,
    input  logic                      i_rd_ready,
    output logic                      o_wr_full,
    output logic [127:0]              o_rd_block,
    output logic                      o_rd_valid,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aes_block_slot_buf: DEPTH must be a power of two and at least 2");
    end

    aes_block_t          r_slot [DEPTH];
    logic [DEPTH-1:0]    r_full;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_level;
    logic                w_pop;

    // An empty read slot can never be popped, so BLOCK_READY is ignored then.
    assign w_pop = r_full[r_rd_ptr] & i_rd_ready & i_ce;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Commit targets an empty slot and pop a full one, so they never
            // collide on the same flag. Pointers wrap naturally (DEPTH = 2^n).
            if (i_wr_commit) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            case ({i_wr_commit, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Block storage carries no reset: stale contents are masked by r_full.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_slot[r_wr_ptr][{i_wr_idx, 3'b000} +: 8] <= i_wr_byte;
        end
    end

    assign o_wr_full  = r_full[r_wr_ptr];
    assign o_rd_valid = r_full[r_rd_ptr];
    assign o_rd_block = r_full[r_rd_ptr] ? r_slot[r_rd_ptr] : '0;
    assign o_level    = r_level;

endmodule

// File: rtl/aes_block_assembler.sv
// ---------------------------------------------------------------------------
// aes_block_assembler
// Packs a byte-serial valid/ready stream into 128-bit AES state blocks and
// presents them to the round core over ready/valid, with a DEPTH-slot
// ping-pong buffer so the next block can stream in while the core works.
// Byte k (k = 1..16) of a block lands in bits [k*8-1 -: 8].
//
// Optional build macro: AES_ASM_TIMEOUT_EN
//   When defined, a partial block that sees TIMEOUT_CYCLES enabled cycles
//   without an accepted byte is discarded and ERR_O pulses for one cycle.
//   When undefined, partial blocks wait indefinitely and ERR_O is 0.
//
// Ports:
//   CLK_I          : clock, rising edge
//   RESET_I        : synchronous reset, active-high
//   CE_I           : clock enable; low freezes all state
//   DATA_I/VALID_I : incoming byte and its valid
//   READY_O        : a byte can be accepted this cycle
//   BLOCK_O        : assembled block at the read slot
//   BLOCK_VALID_O  : BLOCK_O holds a complete block
//   BLOCK_READY_I  : core consumes BLOCK_O
//   LEVEL_O        : number of complete blocks held
//   ERR_O          : one-cycle pulse on partial-block abort
// ---------------------------------------------------------------------------
module aes_block_assembler
    import aes_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   CLK_I,
    input  logic                   RESET_I,
    input  logic                   CE_I,
    input  logic [7:0]             DATA_I,
    input  logic                   VALID_I,
    output logic                   READY_O,
    output logic [127:0]           BLOCK_O,
    output logic                   BLOCK_VALID_O,
    input  logic                   BLOCK_READY_I,
    output logic [$clog2(DEPTH):0] LEVEL_O,
    output logic                   ERR_O
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_block_assembler: TIMEOUT_CYCLES must be at least 1");
    end

    wr_state_t                 r_state;
    logic [AES_BYTE_CNT_W-1:0] r_byte_cnt;
    logic                      w_wr_full;
    logic                      w_accept;
    logic                      w_last;

    // READY depends only on registered slot state plus CE/RESET, never on
    // VALID_I or BLOCK_READY_I.
    assign READY_O  = CE_I & ~RESET_I & ~w_wr_full;
    assign w_accept = VALID_I & READY_O;
    assign w_last   = w_accept & (r_byte_cnt == AES_BYTE_CNT_W'(AES_BLOCK_BYTES - 1));

`ifdef AES_ASM_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_err;
    logic              w_abort;

    // Abort on the TIMEOUT_CYCLES-th consecutive enabled cycle without a byte.
    assign w_abort = CE_I & (r_state == WR_FILLING) & ~w_accept &
                     (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign ERR_O   = r_err;
`else
    assign ERR_O   = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RESET_I) begin
            r_state    <= WR_IDLE;
            r_byte_cnt <= '0;
`ifdef AES_ASM_TIMEOUT_EN
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
`ifdef AES_ASM_TIMEOUT_EN
            r_err <= w_abort;
            if (CE_I) begin
                if (w_accept || w_abort || r_state != WR_FILLING) begin
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
`endif
            // Counter wraps 15 -> 0 on the 16th byte by natural overflow.
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            case (r_state)
                WR_IDLE: begin
                    if (w_accept) begin
                        r_state <= WR_FILLING;
                    end
                end
                WR_FILLING: begin
                    if (w_last) begin
                        r_state <= WR_IDLE;
                    end
`ifdef AES_ASM_TIMEOUT_EN
                    else if (w_abort) begin
                        r_state    <= WR_IDLE;
                        r_byte_cnt <= '0;
                    end
`endif
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

    aes_block_slot_buf #(
        .DEPTH(DEPTH)
    ) u_slot_buf (
        .i_clk       (CLK_I),
        .i_rst       (RESET_I),
        .i_ce        (CE_I),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_byte_cnt),
        .i_wr_byte   (DATA_I),
        .i_wr_commit (w_last),
        .i_rd_ready  (BLOCK_READY_I),
        .o_wr_full   (w_wr_full),
        .o_rd_block  (BLOCK_O),
        .o_rd_valid  (BLOCK_VALID_O),
        .o_level     (LEVEL_O)
    );

endmodule
